hazard_stall_ctrl: RTL and testbench

- Issues stall, bubble, flush and freeze controls for the 5-stage pipeline, covering every hazard that forwarding cannot resolve.
- Handles three cases: load-use dependences (1-cycle stall), taken-branch redirects (flush IF/ID and ID/EX) and data-memory wait states (full pipeline freeze).
- Counts freeze cycles with a watchdog, keeps saturating performance counters and sits beside the forwarding unit in the core top level.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/sat_counter.sv | 41 ++++
 rtl/hazard_stall_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared types and codes for the hazard / stall controller and the
//          forwarding unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  // Stall controller state: normal issue or data-memory freeze in progress
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } stall_state_t;

  // Forward-select codes shared with the forwarding unit
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // True when a producer rd feeds a source operand that is actually read.
  // x0 is hard-wired to zero, so it never creates a dependence.
  function automatic logic reg_dep(input logic [4:0] rd,
                                   input logic       uses,
                                   input logic [4:0] rs);
    return uses && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage : hazard_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: step by one unless already saturated
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Count register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module : hazard_stall_ctrl
// Brief  : Pipeline hazard controller. Produces stall / bubble / flush
//          controls for load-use dependences, taken-branch redirects and
//          data-memory wait states, with a freeze watchdog and saturating
//          performance counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       if_id_rs1_addr,
  input  logic [4:0]       if_id_rs2_addr,
  input  logic             if_id_uses_rs1,
  input  logic             if_id_uses_rs2,
  input  logic [4:0]       id_ex_rd_addr,
  input  logic             id_ex_memread,
  input  logic             ex_branch_taken,
  input  logic             ex_mem_memaccess,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             id_ex_bubble,
  output logic             mem_wb_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Wide enough to hold TIMEOUT_CYCLES so the threshold is always reachable
  localparam int          WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  stall_state_t      state_q,   state_d;
  logic [WAIT_W-1:0] wait_q,    wait_d;
  logic              timeout_q, timeout_d;

  logic freeze;
  logic load_use;
  logic act_freeze;
  logic act_flush;
  logic act_load_use;

  // Hazard detection. The action selection is strictly prioritised so that
  // exactly one action (or none) is taken each cycle; everything is masked
  // while reset is held so the pipeline sees quiet controls immediately.
  always_comb begin
    freeze   = ex_mem_memaccess && !dmem_ready;
    load_use = id_ex_memread &&
               (reg_dep(id_ex_rd_addr, if_id_uses_rs1, if_id_rs1_addr) ||
                reg_dep(id_ex_rd_addr, if_id_uses_rs2, if_id_rs2_addr));

    act_freeze   = !rst && freeze;
    // A branch resolved in a frozen EX stays there, so its flush is simply
    // deferred to the release cycle.
    act_flush    = !rst && !freeze && ex_branch_taken;
    // The ID instruction behind a taken branch is on the wrong path, so its
    // load-use dependence does not matter.
    act_load_use = !rst && !freeze && !ex_branch_taken && load_use;
  end

  // Map the selected action onto the individual pipeline controls
  always_comb begin
    pc_stall      = act_freeze || act_load_use;
    if_id_stall   = act_freeze || act_load_use;
    id_ex_stall   = act_freeze;
    ex_mem_stall  = act_freeze;
    id_ex_bubble  = act_load_use;
    mem_wb_bubble = act_freeze;
    if_id_flush   = act_flush;
    id_ex_flush   = act_flush;
  end

  // Freeze tracking and watchdog next-state
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    if (freeze) begin
      state_d = MEM_WAIT;
      if (wait_q != WAIT_MAX) begin
        wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
      end
      // The access is never aborted; the flag only reports the long wait
      if (wait_q >= WAIT_LAST) begin
        timeout_d = 1'b1;
      end
    end else begin
      state_d = RUN;
      if (state_q == MEM_WAIT) begin
        wait_d = '0;
      end
    end
  end

  // State, wait counter and sticky timeout registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (act_load_use),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (act_freeze),
    .count (freeze_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (act_flush),
    .count (flush_cnt)
  );

endmodule : hazard_stall_ctrl

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// Module : tb_hazard_stall_ctrl
// Brief  : Self-checking bench for hazard_stall_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

  localparam int CNT_W = 32;
  localparam int TMO   = 8;

  // Expected control vector:
  // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
  //  id_ex_bubble, mem_wb_bubble, if_id_flush, id_ex_flush}
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_LU   = 8'b1100_1000;
  localparam logic [7:0] C_FL   = 8'b0000_0011;
  localparam logic [7:0] C_FZ   = 8'b1111_0100;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       ma;
    logic       rdy;
    logic [7:0] exp_ctrl;
    logic       exp_to;
  } vec_t;

  typedef struct {
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] freeze;
    logic [CNT_W-1:0] flush;
  } cnt_t;

  logic             clk;
  logic             rst;
  logic [4:0]       rs1, rs2, rd;
  logic             u1, u2, mr, br, ma, rdy;
  logic             pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic             id_ex_bubble, mem_wb_bubble, if_id_flush, id_ex_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt, freeze_cnt, flush_cnt;
  logic [7:0]       ctrl;

  int   n_checks;
  int   n_fail;
  cnt_t model;
  cnt_t sb[$];
  vec_t vecs[$];

  hazard_stall_ctrl #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .if_id_rs1_addr   (rs1),
    .if_id_rs2_addr   (rs2),
    .if_id_uses_rs1   (u1),
    .if_id_uses_rs2   (u2),
    .id_ex_rd_addr    (rd),
    .id_ex_memread    (mr),
    .ex_branch_taken  (br),
    .ex_mem_memaccess (ma),
    .dmem_ready       (rdy),
    .pc_stall         (pc_stall),
    .if_id_stall      (if_id_stall),
    .id_ex_stall      (id_ex_stall),
    .ex_mem_stall     (ex_mem_stall),
    .id_ex_bubble     (id_ex_bubble),
    .mem_wb_bubble    (mem_wb_bubble),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .mem_timeout      (mem_timeout),
    .stall_cnt        (stall_cnt),
    .freeze_cnt       (freeze_cnt),
    .flush_cnt        (flush_cnt)
  );

  assign ctrl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                 id_ex_bubble, mem_wb_bubble, if_id_flush, id_ex_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                              input logic u1_v, input logic u2_v,
                              input logic [4:0] rd_v, input logic mr_v,
                              input logic br_v, input logic ma_v, input logic rdy_v,
                              input logic [7:0] e, input logic eto);
    vec_t v;
    v.rs1 = rs1_v; v.rs2 = rs2_v; v.u1 = u1_v; v.u2 = u2_v; v.rd = rd_v;
    v.mr = mr_v; v.br = br_v; v.ma = ma_v; v.rdy = rdy_v;
    v.exp_ctrl = e; v.exp_to = eto;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rs1 = v.rs1; rs2 = v.rs2; u1 = v.u1; u2 = v.u2; rd = v.rd;
    mr = v.mr; br = v.br; ma = v.ma; rdy = v.rdy;
  endtask

  // One cycle: drive, check same-cycle controls, push counter expectation,
  // then pop and compare once the edge has registered the event.
  task automatic apply(input vec_t v, input string tag);
    cnt_t e;
    @(negedge clk);
    drive(v);
    #1;
    check({tag, "_ctrl"}, {24'd0, ctrl}, {24'd0, v.exp_ctrl});
    check({tag, "_timeout"}, {31'd0, mem_timeout}, {31'd0, v.exp_to});
    if (v.exp_ctrl == C_LU) model.stall++;
    if (v.exp_ctrl == C_FZ) model.freeze++;
    if (v.exp_ctrl == C_FL) model.flush++;
    sb.push_back(model);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_stall_cnt"},  stall_cnt,  e.stall);
      check({tag, "_freeze_cnt"}, freeze_cnt, e.freeze);
      check({tag, "_flush_cnt"},  flush_cnt,  e.flush);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model    = '{default: '0};

    // Reset with a load-use pattern present: controls must stay quiet
    rst = 1'b1;
    drive(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, C_NONE, 1'b0));
    #2;
    check("reset_ctrl",       {24'd0, ctrl}, 32'd0);
    check("reset_timeout",    {31'd0, mem_timeout}, 32'd0);
    check("reset_stall_cnt",  stall_cnt,  32'd0);
    check("reset_freeze_cnt", freeze_cnt, 32'd0);
    check("reset_flush_cnt",  flush_cnt,  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 1'b0));

    //               rs1    rs2    u1    u2    rd     mr    br    ma    rdy   exp     to
    vecs.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 1'b0));
    vecs.push_back(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, C_LU,   1'b0));
    vecs.push_back(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, C_NONE, 1'b0));
    vecs.push_back(mk(5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, C_NONE, 1'b0));
    vecs.push_back(mk(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, C_LU,   1'b0));
    vecs.push_back(mk(5'd9, 5'd3, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, C_FL,   1'b0));
    // Memory wait with a pending branch, then release
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_FZ, 1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, C_FL,   1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 1'b0));
    // Freeze beats a coincident load-use
    vecs.push_back(mk(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, C_FZ,   1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE, 1'b0));
    // Watchdog: flag visible from the 9th frozen cycle onward
    for (int i = 1; i <= 10; i++)
      vecs.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_FZ, (i > TMO)));
    vecs.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE, 1'b1));
    vecs.push_back(mk(5'd2, 5'd6, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, C_LU,   1'b1));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a freeze
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_FZ, 1'b1), "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ctrl",       {24'd0, ctrl}, 32'd0);
    check("midrst_timeout",    {31'd0, mem_timeout}, 32'd0);
    check("midrst_stall_cnt",  stall_cnt,  32'd0);
    check("midrst_freeze_cnt", freeze_cnt, 32'd0);
    check("midrst_flush_cnt",  flush_cnt,  32'd0);
    model = '{default: '0};
    sb.delete();
    drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 1'b0));
    #1;
    rst = 1'b0;
    apply(mk(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, C_LU,   1'b0), "post_rst_lu");
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, C_FL,   1'b0), "post_rst_br");
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 1'b0), "post_rst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_hazard_stall_ctrl

`default_nettype wire
